// File: rtl/flash_read_arbiter.sv
// Arbitrates the shared SPI flash read engine between icache and dcache misses,
// with an icache starvation guard, a WAIT watchdog and discard of withdrawn requests.
module flash_read_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 200
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    output logic [1:0]        mode,
    output logic [DATA_W-1:0] rd_data,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic              spi_req,
    output logic [ADDR_W-1:0] spi_addr,
    input  logic              spi_ready,
    input  logic              spi_data_valid,
    input  logic [DATA_W-1:0] spi_data,
    output logic              timeout_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_D = 2'd1, OWN_I = 2'd2} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, mask_q;
    logic [SW-1:0]   starve_q;
    logic [7:0]      wd_q;
    logic            elig_i, elig_d, grant_i, grant_d;
    logic            owner_miss, timeout_hit, starving;

    assign starving    = (starve_q == SW'(STARVE_LIMIT));
    assign timeout_hit = (wd_q == 8'(TIMEOUT - 1));
    assign owner_miss  = (owner_q == OWN_I) ? icache_miss : dcache_miss;

    // dcache has priority unless icache has been starved; masked requester sits out one IDLE cycle
    always_comb begin
        elig_i  = icache_miss && (mask_q != OWN_I);
        elig_d  = dcache_miss && (mask_q != OWN_D);
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (elig_i && (starving || !elig_d))
                grant_i = 1'b1;
            else if (elig_d)
                grant_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_i || grant_d) state_d = ISSUE;
            ISSUE: begin
                // an accepted handshake cannot be recalled; withdrawal only counts before acceptance
                if (spi_ready)        state_d = WAIT;
                else if (!owner_miss) state_d = IDLE;
            end
            WAIT: begin
                if (spi_data_valid)   state_d = owner_miss ? DELIVER : IDLE;
                else if (timeout_hit) state_d = IDLE;
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            mask_q      <= OWN_NONE;
            starve_q    <= '0;
            wd_q        <= '0;
            spi_addr    <= '0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state_q == WAIT) && !spi_data_valid && timeout_hit;
            case (state_q)
                IDLE: begin
                    mask_q <= OWN_NONE;
                    wd_q   <= '0;
                    if (grant_i) begin
                        owner_q  <= OWN_I;
                        spi_addr <= icache_addr;
                        starve_q <= '0;
                    end else if (grant_d) begin
                        owner_q  <= OWN_D;
                        spi_addr <= dcache_addr;
                        if (icache_miss && !starving)
                            starve_q <= starve_q + SW'(1);
                    end
                end
                ISSUE: wd_q <= '0;
                WAIT: begin
                    wd_q <= wd_q + 8'd1;
                    if (spi_data_valid)
                        rd_data <= spi_data;
                end
                DELIVER: mask_q <= owner_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        mode              = (state_q == IDLE) ? 2'd0 : owner_q;
        spi_req           = (state_q == ISSUE);
        icache_data_valid = (state_q == DELIVER) && (owner_q == OWN_I);
        dcache_data_valid = (state_q == DELIVER) && (owner_q == OWN_D);
    end

endmodule
